// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the load/store unit: funct3 encodings,
// access-size codes, FSM state encodings and request legality checks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Access size is carried in funct3[1:0] for both loads and stores.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE  = 2'd0;
    localparam lsu_state_t ST_EXEC  = 2'd1;
    localparam lsu_state_t ST_WRITE = 2'd2;
    localparam lsu_state_t ST_RESP  = 2'd3;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return f3 inside {F3_B, F3_H, F3_W};
        else
            return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extended load extraction and sub-word store
// merging into a full memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] load_word,
    input  logic [31:0] store_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = load_word[{off, 3'b000} +: 8];
        lane_h = off[1] ? load_word[31:16] : load_word[15:0];
        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h000000, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0000, lane_h};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        merge_data = store_word;
        case (funct3[1:0])
            SZ_B: merge_data[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_H: begin
                if (off[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0] = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: accepts one access at a time, rejects bad requests
// without touching memory, and performs sub-word stores as read-modify-write.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        we_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] merge_q;

    logic        accept;
    logic        req_bad;
    logic        sub_word;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign accept   = req & ready;
    assign req_bad  = !f3_legal(req_we, req_funct3)
                    | misaligned(req_funct3, req_addr[1:0])
                    | ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    assign sub_word = funct3_q[1:0] != SZ_W;

    lsu_align u_align (
        .load_word  (mem_rd),
        .store_word (merge_q),
        .wdata      (wdata_q),
        .off        (addr_q[1:0]),
        .funct3     (funct3_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr_q   <= '0;
            funct3_q <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
            rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata;
                        err_q    <= req_bad;
                        state    <= req_bad ? ST_RESP : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!we_q) begin
                        rdata <= load_data;
                        state <= ST_RESP;
                    end else if (sub_word) begin
                        merge_q <= mem_rd;
                        state   <= ST_WRITE;
                    end else begin
                        state <= ST_RESP;
                    end
                end
                ST_WRITE: state <= ST_RESP;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign ready = state == ST_IDLE;
    assign done  = state == ST_RESP;
    assign err   = done & err_q;
    assign mem_a = {addr_q[31:2], 2'b00};

    // Decoded from state so an asynchronous reset kills a pending write at once.
    always_comb begin
        mem_we = 1'b0;
        mem_wd = '0;
        case (state)
            ST_EXEC: begin
                if (we_q && !sub_word) begin
                    mem_we = 1'b1;
                    mem_wd = wdata_q;
                end
            end
            ST_WRITE: begin
                mem_we = 1'b1;
                mem_wd = merge_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a behavioural memory and reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:63];
    logic        mem_clr;

    logic [31:0] ref_mem [0:63];
    logic [31:0] last_rdata;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a[7:2]];

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        return !legal || ((addr % op_bytes(f3)) != 0) || ((addr / 4) >= 64);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr, input logic [2:0] f3);
        logic [31:0] v;
        v = w >> (8 * (addr % 4));
        if (op_bytes(f3) == 1) begin
            v = v & 32'hFF;
            if (f3 == 3'd0 && v >= 128) v = v - 256;
        end else if (op_bytes(f3) == 2) begin
            v = v & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] addr,
                                                input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] mask;
        if (op_bytes(f3) == 4) return wd;
        mask = (op_bytes(f3) == 1 ? 32'hFF : 32'hFFFF) << (8 * (addr % 4));
        return (old & ~mask) | ((wd << (8 * (addr % 4))) & mask);
    endfunction

    task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            output int e_done, output logic e_err, output logic [31:0] e_rdata,
                            output logic [7:0] e_mask, output logic [31:0] e_wd);
        e_err = model_err(we, f3, addr);
        e_mask = 8'h00;
        e_wd = '0;
        if (e_err) begin
            e_done = 1;
        end else if (!we) begin
            e_done = 2;
            last_rdata = model_load(ref_mem[addr / 4], addr, f3);
        end else begin
            e_wd = model_store(ref_mem[addr / 4], addr, f3, wd);
            ref_mem[addr / 4] = e_wd;
            e_done = (op_bytes(f3) == 4) ? 2 : 3;
            e_mask = (op_bytes(f3) == 4) ? 8'b0000_0010 : 8'b0000_0100;
        end
        e_rdata = last_rdata;
    endtask

    // ---------------- driver ----------------
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          output int done_cyc, output logic err_o, output logic [31:0] rdata_o,
                          output logic [7:0] we_mask, output logic [31:0] wd_o, output logic [31:0] a_o);
        @(negedge clk);
        req = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        done_cyc = 0; err_o = 1'b0; rdata_o = '0; we_mask = '0; wd_o = '0; a_o = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_mask[k] = 1'b1;
                wd_o = mem_wd;
                a_o = mem_a;
            end
            if (done) begin
                done_cyc = k;
                err_o = err;
                rdata_o = rdata;
                break;
            end
        end
    endtask

    int          d_c, e_d;
    logic        er, e_er;
    logic [31:0] rd, e_rd, wdo, e_wd, ao;
    logic [7:0]  msk, e_msk;

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
        n_checks++; if (mem_wd !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wd got=%h exp=0", mem_wd); end
    endtask

    task automatic test_sw_lw();
        model_op(1'b1, 3'd2, 32'h10, 32'h882244FF, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b1, 3'd2, 32'h10, 32'h882244FF, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (msk !== 8'b0000_0010) begin n_fail++; $display("FAIL sw_we_cycles got=%b exp=00000010", msk); end
        n_checks++; if (ao !== 32'h10) begin n_fail++; $display("FAIL sw_mem_a got=%h exp=00000010", ao); end
        n_checks++; if (wdo !== 32'h882244FF) begin n_fail++; $display("FAIL sw_mem_wd got=%h exp=882244ff", wdo); end
        n_checks++; if (d_c !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL sw_done got=%0d/err%b exp=2/err0", d_c, er); end
        model_op(1'b0, 3'd2, 32'h10, 32'h0, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b0, 3'd2, 32'h10, 32'h0, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (d_c !== 2) begin n_fail++; $display("FAIL lw_done_cycle got=%0d exp=2", d_c); end
        n_checks++; if (rd !== 32'h882244FF) begin n_fail++; $display("FAIL lw_rdata got=%h exp=882244ff", rd); end
    endtask

    task automatic test_extension();
        logic [2:0]  f3_t [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] ad_t [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] ex_t [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8822, 32'h000044FF};
        for (int i = 0; i < 4; i++) begin
            model_op(1'b0, f3_t[i], ad_t[i], 32'h0, e_d, e_er, e_rd, e_msk, e_wd);
            run_op(1'b0, f3_t[i], ad_t[i], 32'h0, d_c, er, rd, msk, wdo, ao);
            n_checks++;
            if (rd !== ex_t[i] || d_c !== 2 || er !== 1'b0) begin
                n_fail++;
                $display("FAIL ext_%0d got=%h done%0d err%b exp=%h done2 err0", i, rd, d_c, er, ex_t[i]);
            end
        end
    endtask

    task automatic test_subword();
        model_op(1'b1, 3'd0, 32'h11, 32'h000000AB, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b1, 3'd0, 32'h11, 32'h000000AB, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (msk !== 8'b0000_0100) begin n_fail++; $display("FAIL sb_we_cycles got=%b exp=00000100", msk); end
        n_checks++; if (wdo !== 32'h8822ABFF) begin n_fail++; $display("FAIL sb_mem_wd got=%h exp=8822abff", wdo); end
        n_checks++; if (d_c !== 3) begin n_fail++; $display("FAIL sb_done_cycle got=%0d exp=3", d_c); end
        model_op(1'b0, 3'd2, 32'h10, 32'h0, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b0, 3'd2, 32'h10, 32'h0, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (rd !== 32'h8822ABFF) begin n_fail++; $display("FAIL sb_readback got=%h exp=8822abff", rd); end
        model_op(1'b1, 3'd1, 32'h12, 32'h00001234, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b1, 3'd1, 32'h12, 32'h00001234, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (wdo !== 32'h1234ABFF || d_c !== 3) begin n_fail++; $display("FAIL sh_write got=%h done%0d exp=1234abff done3", wdo, d_c); end
        model_op(1'b0, 3'd2, 32'h10, 32'h0, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b0, 3'd2, 32'h10, 32'h0, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (rd !== 32'h1234ABFF) begin n_fail++; $display("FAIL sh_readback got=%h exp=1234abff", rd); end
    endtask

    task automatic test_errors();
        logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]  f3_t [4] = '{3'd1, 3'd2, 3'd2, 3'd3};
        logic [31:0] ad_t [4] = '{32'h11, 32'h102, 32'h100, 32'h10};
        for (int i = 0; i < 4; i++) begin
            model_op(we_t[i], f3_t[i], ad_t[i], 32'hDEADBEEF, e_d, e_er, e_rd, e_msk, e_wd);
            run_op(we_t[i], f3_t[i], ad_t[i], 32'hDEADBEEF, d_c, er, rd, msk, wdo, ao);
            n_checks++; if (d_c !== 1 || er !== 1'b1) begin n_fail++; $display("FAIL err_%0d_resp got=done%0d err%b exp=done1 err1", i, d_c, er); end
            n_checks++; if (msk !== 8'h00) begin n_fail++; $display("FAIL err_%0d_mem_we got=%b exp=00000000", i, msk); end
            n_checks++; if (rd !== 32'h1234ABFF) begin n_fail++; $display("FAIL err_%0d_rdata got=%h exp=1234abff", i, rd); end
        end
    endtask

    task automatic test_reset_mid_rmw();
        logic saw_done;
        @(negedge clk);
        req = 1'b1; req_we = 1'b1; req_funct3 = 3'd1; req_addr = 32'h10; req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (mem_we !== 1'b1) begin n_fail++; $display("FAIL rmw_write_cycle mem_we got=%b exp=1", mem_we); end
        #1 reset = 1'b1;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_reset_mem_we got=%b exp=0", mem_we); end
        n_checks++;
        if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
            n_fail++;
            $display("FAIL rmw_reset_outputs got=rdy%b done%b err%b rd%h a%h wd%h exp=rdy1 done0 err0 zeros",
                     ready, done, err, rdata, mem_a, mem_wd);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_rdata = '0;
        n_checks++; if (mem[4] !== ref_mem[4]) begin n_fail++; $display("FAIL rmw_word_unchanged got=%h exp=%h", mem[4], ref_mem[4]); end
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rmw_no_done got=%b exp=0", saw_done); end
        model_op(1'b0, 3'd2, 32'h10, 32'h0, e_d, e_er, e_rd, e_msk, e_wd);
        run_op(1'b0, 3'd2, 32'h10, 32'h0, d_c, er, rd, msk, wdo, ao);
        n_checks++; if (rd !== e_rd || d_c !== 2) begin n_fail++; $display("FAIL rmw_after_lw got=%h done%0d exp=%h done2", rd, d_c, e_rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad_t [3] = '{32'h20, 32'h24, 32'h28};
        logic [31:0] exp_t [3];
        int          done_at [3];
        logic [31:0] got_t [3];
        int          acc_at [3];
        int          nd, idx;
        for (int i = 0; i < 3; i++) begin
            exp_t[i] = $urandom;
            model_op(1'b1, 3'd2, ad_t[i], exp_t[i], e_d, e_er, e_rd, e_msk, e_wd);
            run_op(1'b1, 3'd2, ad_t[i], exp_t[i], d_c, er, rd, msk, wdo, ao);
        end
        nd = 0; idx = 0;
        @(negedge clk);
        req = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = ad_t[0]; req_wdata = '0;
        for (int cyc = 0; cyc < 30 && nd < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done && nd < 3) begin
                done_at[nd] = cyc; got_t[nd] = rdata; nd++;
            end
            if (ready && idx < 3) begin
                acc_at[idx] = cyc;
                @(posedge clk);
                #1 idx++;
                if (idx < 3) req_addr = ad_t[idx];
                else req = 1'b0;
            end
        end
        req = 1'b0;
        n_checks++; if (nd !== 3 || idx !== 3) begin n_fail++; $display("FAIL b2b_count got=done%0d acc%0d exp=3/3", nd, idx); end
        for (int i = 0; i < 3 && i < nd; i++) begin
            last_rdata = exp_t[i];
            n_checks++; if (got_t[i] !== exp_t[i]) begin n_fail++; $display("FAIL b2b_rdata_%0d got=%h exp=%h", i, got_t[i], exp_t[i]); end
            n_checks++; if (done_at[i] - acc_at[i] !== 2) begin n_fail++; $display("FAIL b2b_latency_%0d got=%0d exp=2", i, done_at[i] - acc_at[i]); end
            if (i > 0) begin
                n_checks++; if (done_at[i] - done_at[i-1] !== 3) begin n_fail++; $display("FAIL b2b_spacing_%0d got=%0d exp=3", i, done_at[i] - done_at[i-1]); end
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  legal_t [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : legal_t[$urandom_range(0, 7)];
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            wd = $urandom;
            model_op(we, f3, addr, wd, e_d, e_er, e_rd, e_msk, e_wd);
            run_op(we, f3, addr, wd, d_c, er, rd, msk, wdo, ao);
            n_checks++;
            if (d_c !== e_d || er !== e_er || rd !== e_rd || msk !== e_msk) begin
                n_fail++;
                $display("FAIL rand_%0d we%b f3=%0d a=%h got=done%0d err%b rd%h we%b exp=done%0d err%b rd%h we%b",
                         n, we, f3, addr, d_c, er, rd, msk, e_d, e_er, e_rd, e_msk);
            end
            if (e_msk != 8'h00) begin
                n_checks++;
                if (wdo !== e_wd || ao !== (addr & 32'hFFFF_FFFC)) begin
                    n_fail++;
                    $display("FAIL rand_%0d_write got=wd%h a%h exp=wd%h a%h", n, wdo, ao, e_wd, addr & 32'hFFFF_FFFC);
                end
            end
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (mem[i] !== ref_mem[i]) begin n_fail++; $display("FAIL rand_mem_%0d got=%h exp=%h", i, mem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        req = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        last_rdata = '0;
        repeat (2) @(posedge clk);
        test_reset();
        reset = 1'b0; mem_clr = 1'b0;
        test_reset();
        test_sw_lw();
        test_extension();
        test_subword();
        test_errors();
        test_reset_mid_rmw();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
